arb_n: RTL and testbench
========================

ARB_N -- requirements
Module: arb_n

Interface
REQ-001 Parameter NREQ, default 8, number of internal bus requesters (2..16).
REQ-002 Parameter CPU_LEVEL, default NREQ-2, lowest requester index that outranks a CPU bus-back request.
REQ-003 Parameter IDW, default $clog2(NREQ), width of the encoded grant index.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester bus request, level-held until granted and finished.
REQ-007 mode  input  1  arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-008 ack  input  1  bus-cycle completion strobe; it marks the arbitration point.
REQ-009 bg_in  input  1  external CPU bus grant, active high.
REQ-010 cpu_req  input  1  CPU requests the bus back while the arbiter owns it.
REQ-011 br_out  output  1  bus request to the CPU, active high.
REQ-012 ba  output  1  arbiter owns the bus.
REQ-013 gnt  output  NREQ  one-hot grant, or all zero.
REQ-014 gnt_id  output  IDW  encoded index of the set gnt bit; 0 when gnt is zero.
REQ-015 gnt_valid  output  1  OR of gnt.
REQ-016 cpu_bm  output  1  CPU is bus master (state != OWN).

Function
REQ-017 The state machine shall have three states: CPU, REQ and OWN, all registered.
REQ-018 In CPU, when |req = 1, the next state shall be REQ; otherwise the state stays CPU.
REQ-019 In REQ: bg_in=1 -> OWN; bg_in=0 and |req=0 -> CPU; otherwise stay in REQ.
REQ-020 br_out shall be 1 exactly when the state is REQ, and ba shall be 1 exactly when the state is OWN.
REQ-021 On the edge entering OWN, gnt shall be all zero.
REQ-022 In OWN, an arbitration point shall be any cycle with ack=1 or gnt=0; gnt shall change only at arbitration points.
REQ-023 Eligible set: req, masked to indices >= CPU_LEVEL when cpu_req=1; else all req bits.
REQ-024 In fixed mode, the winner shall be the highest asserted eligible index.
REQ-025 In round-robin mode, the winner shall be the first eligible index scanning from last+1 upward, wrapping modulo NREQ and ending at last.
REQ-026 Round-robin pointer "last" shall load the winner's index at each arbitration point with a winner.
REQ-027 The pointer shall be held otherwise, and in both modes.
REQ-028 At an arbitration point with a winner, gnt shall be the winner one-hot on the next edge.
REQ-029 At an arbitration point with no winner, the next state shall be CPU and gnt shall be 0 on the next edge.
REQ-030 A changed mode value shall take effect at the next arbitration point; no grant is disturbed mid-cycle.
REQ-031 Latencies: req rise in CPU -> br_out after 1 cycle; bg_in sampled in REQ -> ba after 1 cycle; ba -> first gnt after 1 cycle.
REQ-032 bg_in is ignored outside REQ; ack and cpu_req are ignored outside OWN.
REQ-033 gnt_id, gnt_valid and cpu_bm shall be decoded combinationally from the registered state and gnt.
REQ-034 gnt shall never have more than one bit set.

Reset
REQ-035 With reset=1 at an edge, regardless of state: state=CPU, gnt=0, last=NREQ-1, br_out=0, ba=0.
REQ-036 After that reset edge, gnt_id=0, gnt_valid=0 and cpu_bm=1.
REQ-037 A reset asserted mid-OWN shall drop gnt and ba on that edge with no further arbitration.

Verification (NREQ=4, CPU_LEVEL=2)
REQ-038 Fixed handshake: req=0101 and bg_in held 1 from REQ.
-> br_out=1 after 1 cycle; ba=1 after 2 cycles; gnt=0100 after 3 cycles.
REQ-039 Fixed release: req=0001 after the grant, then ack.
-> gnt=0001; next ack with req=0 -> state CPU, gnt=0000, cpu_bm=1.
REQ-040 Round-robin: mode=1, req=1111 held, ack each cycle.
-> gnt sequence 0001,0010,0100,1000,0001.
REQ-041 CPU bus-back: in OWN, cpu_req=1, req=0011, ack.
-> CPU state, gnt=0; repeat with req=1001 -> gnt=1000.
REQ-042 REQ abort: req pulses 0010 for 1 cycle, bg_in=0.
-> br_out=1 for one cycle, then CPU; gnt never asserted.
REQ-043 Reset mid-grant: gnt=0100 and reset=1 for one edge.
-> gnt=0000, ba=0, br_out=0; a following round-robin scan starts at index 0.

Source files
------------

// File: rtl/arb_n.sv
// arb_n: N-way bus arbiter that borrows the bus from a CPU.
// Fixed-priority or round-robin grant, with CPU bus-back masking.
module arb_n #(
  parameter int NREQ      = 8,
  parameter int CPU_LEVEL = NREQ - 2,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            mode,
  input  logic            ack,
  input  logic            bg_in,
  input  logic            cpu_req,
  output logic            br_out,
  output logic            ba,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid,
  output logic            cpu_bm
);

  typedef enum logic [1:0] {
    S_CPU,
    S_REQ,
    S_OWN
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  last_q, last_d;

  logic [NREQ-1:0] elig;
  logic            any_elig;
  logic [IDW-1:0]  fx_idx;
  logic [IDW-1:0]  hi_idx;
  logic [IDW-1:0]  lo_idx;
  logic            hi_hit;
  logic [IDW-1:0]  win_idx;
  logic            arb_pt;

  // Eligible requesters: only the top levels outrank a CPU bus-back
  always_comb begin
    elig = req;
    for (int i = 0; i < NREQ; i++) begin
      if (cpu_req && (i < CPU_LEVEL)) begin
        elig[i] = 1'b0;
      end
    end
  end

  assign any_elig = |elig;

  // Fixed priority: highest eligible index wins
  always_comb begin
    fx_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (elig[i]) begin
        fx_idx = IDW'(i);
      end
    end
  end

  // Round robin: lowest eligible above last, else lowest at/below last
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i] && (i > int'(last_q))) begin
        hi_hit = 1'b1;
        hi_idx = IDW'(i);
      end
      if (elig[i] && (i <= int'(last_q))) begin
        lo_idx = IDW'(i);
      end
    end
  end

  assign win_idx = mode ? (hi_hit ? hi_idx : lo_idx)
                        : fx_idx;

  assign arb_pt = (state_q == S_OWN) &&
                  (ack || (gnt_q == '0));

  // State register, grant and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CPU;
      gnt_q   <= '0;
      last_q  <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state, next-grant and pointer update
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    unique case (state_q)
      S_CPU: begin
        if (|req) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bg_in) begin
          state_d = S_OWN;
        end else if (!(|req)) begin
          state_d = S_CPU;
        end
      end
      S_OWN: begin
        if (arb_pt) begin
          if (any_elig) begin
            gnt_d  = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            last_d = win_idx;
          end else begin
            state_d = S_CPU;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_CPU;
        gnt_d   = '0;
      end
    endcase
  end

  // Grant index encode from the registered one-hot grant
  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        gnt_id = gnt_id | IDW'(i);
      end
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign br_out    = (state_q == S_REQ);
  assign ba        = (state_q == S_OWN);
  assign cpu_bm    = (state_q != S_OWN);

endmodule

// File: tb/tb_arb_n.sv
// tb_arb_n: directed and random checks of arb_n
// against a cycle-level behavioural model.
module tb_arb_n;

  localparam int N  = 4;
  localparam int CL = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         mode;
  logic         ack;
  logic         bg_in;
  logic         cpu_req;
  logic         br_out;
  logic         ba;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         gnt_valid;
  logic         cpu_bm;

  int n_chk  = 0;
  int n_fail = 0;

  // model: 0 = CPU, 1 = REQ, 2 = OWN; m_g = granted index or -1
  int m_st;
  int m_g;
  int m_last;

  arb_n #(.NREQ(N), .CPU_LEVEL(CL)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .mode(mode),
    .ack(ack),
    .bg_in(bg_in),
    .cpu_req(cpu_req),
    .br_out(br_out),
    .ba(ba),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .gnt_valid(gnt_valid),
    .cpu_bm(cpu_bm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int eg;
    eg = (m_g < 0) ? 0 : (1 << m_g);
    chk("br_out", 32'(br_out), 32'(m_st == 1));
    chk("ba", 32'(ba), 32'(m_st == 2));
    chk("gnt", 32'(gnt), eg);
    chk("gnt_id", 32'(gnt_id), (m_g < 0) ? 0 : m_g);
    chk("gnt_valid", 32'(gnt_valid), 32'(m_g >= 0));
    chk("cpu_bm", 32'(cpu_bm), 32'(m_st != 2));
    chk("onehot", 32'($countones(gnt) <= 1), 1);
  endtask

  // advance one clock, moving the model with the pre-edge inputs
  task automatic step();
    int ns, ng, nl, w;
    bit [N-1:0] el;
    ns = m_st; ng = m_g; nl = m_last;
    if (reset) begin
      ns = 0; ng = -1; nl = N - 1;
    end else if (m_st == 0) begin
      if (req != 0) ns = 1;
    end else if (m_st == 1) begin
      if (bg_in) ns = 2;
      else if (req == 0) ns = 0;
    end else if (ack || m_g < 0) begin
      el = req;
      for (int i = 0; i < CL; i++)
        if (cpu_req) el[i] = 1'b0;
      if (el == 0) begin
        ns = 0; ng = -1;
      end else begin
        w = -1;
        if (mode) begin
          for (int k = N; k >= 1; k--)
            if (el[(m_last + k) % N]) w = (m_last + k) % N;
        end else begin
          for (int i = 0; i < N; i++)
            if (el[i]) w = i;
        end
        ng = w; nl = w;
      end
    end
    @(posedge clk);
    #1;
    m_st = ns; m_g = ng; m_last = nl;
    check_all();
  endtask

  initial begin
    reset = 1'b1; req = '0; mode = 1'b0; ack = 1'b0;
    bg_in = 1'b0; cpu_req = 1'b0;
    m_st = 2; m_g = 0; m_last = 0;
    step();
    reset = 1'b0;
    chk("rst_cpu_bm", 32'(cpu_bm), 1);

    // fixed handshake
    req = 4'b0101; bg_in = 1'b1;
    step();
    chk("hs_br", 32'(br_out), 1);
    step();
    chk("hs_ba", 32'(ba), 1);
    step();
    chk("hs_gnt", 32'(gnt), 32'h4);

    // fixed release
    req = 4'b0001; ack = 1'b1;
    step();
    chk("rel_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    step();
    chk("rel_cpu", 32'(cpu_bm), 1);

    // round robin from reset pointer
    reset = 1'b1; step(); reset = 1'b0;
    mode = 1'b1; req = 4'b1111; bg_in = 1'b1; ack = 1'b1;
    step(); step(); step();
    chk("rr0", 32'(gnt), 32'h1);
    step(); chk("rr1", 32'(gnt), 32'h2);
    step(); chk("rr2", 32'(gnt), 32'h4);
    step(); chk("rr3", 32'(gnt), 32'h8);
    step(); chk("rr4", 32'(gnt), 32'h1);

    // CPU bus-back
    mode = 1'b0; cpu_req = 1'b1; req = 4'b0011;
    step();
    chk("bb_cpu", 32'(cpu_bm), 1);
    req = 4'b1001; ack = 1'b0;
    step(); step(); step();
    chk("bb_gnt", 32'(gnt), 32'h8);

    // REQ abort
    cpu_req = 1'b0; req = '0; ack = 1'b1;
    step();
    bg_in = 1'b0; req = 4'b0010;
    step();
    chk("ab_br", 32'(br_out), 1);
    req = '0;
    step();
    chk("ab_cpu", 32'(br_out), 0);
    step();

    // reset mid-grant, then round-robin starts at 0
    req = 4'b0100; bg_in = 1'b1; ack = 1'b0;
    step(); step(); step();
    chk("mg_gnt", 32'(gnt), 32'h4);
    reset = 1'b1;
    step();
    chk("mg_ba", 32'(ba), 0);
    reset = 1'b0; mode = 1'b1; req = 4'b1111;
    step(); step(); step();
    chk("mg_rr", 32'(gnt), 32'h1);

    // random traffic
    for (int t = 0; t < 400; t++) begin
      req     = 4'($urandom);
      mode    = 1'($urandom_range(0, 7) == 0 ? ~mode : mode);
      ack     = 1'($urandom);
      bg_in   = 1'($urandom_range(0, 3) != 0);
      cpu_req = 1'($urandom_range(0, 4) == 0);
      reset   = 1'($urandom_range(0, 60) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
